vec_wb_buffer: RTL and testbench
================================

Name: vec_wb_buffer

Overview:
- Writeback stage directly downstream of ALU_vec.
- Buffers each ALU_vec result (256-bit vector of 16 x 16-bit Q8.8 lanes, plus 64-bit per-lane flags) in a small FIFO and drains it into the vector register file write port under a valid/ready handshake.
- Generates the lane write mask for scalar vs vector operations.
- Keeps a sticky per-lane flag register for software inspection.

Parameters:
- DEPTH, 4: FIFO entries, power of two, minimum 2.
- ADDR_W, 5: vector register address width.
- LANES, 16: lanes per vector.
- LANE_W, 16: bits per lane.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  buffer can accept.
- in_result  in  LANES*LANE_W  ALU_vec result; lane i at [16i+15:16i].
- in_flags  in  LANES*4  ALU_vec flags; lane i at [4i+3:4i].
- in_scalar  in  1  op was scalar (flag_scalar); only lane 0 is meaningful.
- in_rd  in  ADDR_W  destination vector register.
- in_wb_en  in  1  1 = write the register file; 0 = flags-only op.
- wr_en  out  1  register file write request.
- wr_ready  in  1  register file accepts the write this cycle.
- wr_addr  out  ADDR_W  destination register.
- wr_data  out  LANES*LANE_W  data to write.
- wr_mask  out  LANES  per-lane write enable.
- clr_flags  in  1  clear the sticky flags.
- sticky_flags  out  LANES*4  OR of committed flags.
- count  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, active-high): read/write pointers = 0, count = 0, sticky_flags = 0, wr_en = 0, in_ready = 1.
  - Reset mid-operation discards all entries; no write is issued after reset deasserts until a new push.
- Push: occurs on a rising edge when in_valid && in_ready.
  - in_ready = (count < DEPTH), registered-state only.
  - No combinational path from wr_ready to in_ready.
- FIFO is first-word-fall-through. An entry pushed at edge N is presented at the head during the cycle after edge N (1-cycle latency when empty).
- Head presentation when count > 0:
  - wr_addr = head rd; wr_data = head result.
  - wr_mask = 16'h0001 if head scalar, else 16'hFFFF.
  - wr_en = head wb_en. wr_en = 0 when empty.
- Pop (retire):
  - If head wb_en = 1: pop on an edge with wr_en && wr_ready.
  - If head wb_en = 0: pop unconditionally on the next edge; wr_ready is ignored.
- Simultaneous push and pop: count is unchanged. This is legal at any occupancy below DEPTH; at DEPTH, in_ready = 0, so no push occurs.
- Pointers wrap modulo DEPTH. count runs 0..DEPTH and is never exceeded.
- Sticky flags update only at pop, never at push.
  - Committed flags = head flags masked to nibble [3:0] if scalar, else all 64 bits.
  - sticky_flags <= (clr_flags ? 0 : sticky_flags) | (pop ? committed : 0).
  - Clear and pop in the same cycle therefore leave exactly the popped entry's flags.
- Data passes through unmodified; no arithmetic on lanes.
- in_* values are ignored when in_valid = 0.
- All outputs other than wr_* head fields are registered.

Test Plan:
- Reset then idle -> count = 0, wr_en = 0, in_ready = 1, sticky_flags = 0.
- Single vector push: in_result lane0 = 16'hFE20, lane15 = 16'hFD60, in_rd = 5, flags lane0 = 4'b0010, in_scalar = 0, wr_ready = 1.
  - Next cycle: wr_en = 1, wr_addr = 5, wr_mask = 16'hFFFF, wr_data equal to the pushed result.
  - Following cycle: count = 0, sticky_flags[3:0] = 4'b0010.
- Scalar push, lane0 = 16'hFE20, flags = 64'hFFFF_FFFF_FFFF_FFF1 -> wr_mask = 16'h0001, sticky_flags = 64'h1 after retire.
- Backpressure: wr_ready = 0, push 5 entries back-to-back.
  - First 4 accepted; in_ready = 0 with count = 4.
  - Raise wr_ready -> writes emerge in order rd = 0, 1, 2, 3, one per cycle; the 5th entry is accepted the cycle after the first pop.
- Wrap and concurrency: continuous push/pop for 10 entries with wr_ready = 1 -> count stays 1, all 10 written in order, pointers wrap without loss.
- Flags-only entry (in_wb_en = 0) with wr_ready = 0 -> wr_en stays 0, entry retires in 1 cycle, flags ORed.
- clr_flags asserted in the same cycle as a pop with flags 4'b0100 -> sticky_flags = 64'h4.
- Assert rst with 3 entries queued -> count = 0 immediately, wr_en = 0, no writes after release.

Source files
------------

// File: rtl/vec_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module  : vec_wb_buffer
// Purpose : ALU_vec writeback FIFO (first-word-fall-through) that drains into the
//           vector register file, generates lane masks and keeps sticky flags.
// Revision: 1.0 - initial release
// ============================================================================
module vec_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int LANES  = 16,
    parameter int LANE_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*LANE_W-1:0]      in_result,
    input  logic [LANES*4-1:0]           in_flags,
    input  logic                         in_scalar,
    input  logic [ADDR_W-1:0]            in_rd,
    input  logic                         in_wb_en,

    output logic                         wr_en,
    input  logic                         wr_ready,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [LANES*LANE_W-1:0]      wr_data,
    output logic [LANES-1:0]             wr_mask,

    input  logic                         clr_flags,
    output logic [LANES*4-1:0]           sticky_flags,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int DATA_W = LANES * LANE_W;
    localparam int FLAG_W = LANES * 4;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Entry storage; no reset needed because occupancy gates every use.
    logic [DATA_W-1:0] data_mem   [DEPTH];
    logic [FLAG_W-1:0] flags_mem  [DEPTH];
    logic [ADDR_W-1:0] rd_mem     [DEPTH];
    logic              scalar_mem [DEPTH];
    logic              wben_mem   [DEPTH];

    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic [FLAG_W-1:0] sticky_q, sticky_d;

    logic              push;
    logic              pop;
    logic              not_empty;
    logic              head_scalar;
    logic              head_wben;
    logic [FLAG_W-1:0] head_flags;
    logic [FLAG_W-1:0] committed;

    assign not_empty   = (count_q != '0);
    assign head_scalar = scalar_mem[rptr_q];
    assign head_wben   = wben_mem[rptr_q];
    assign head_flags  = flags_mem[rptr_q];

    assign push = in_valid & ready_q;
    // Flags-only entries carry no register write, so they retire without waiting.
    assign pop  = not_empty & (~head_wben | wr_ready);

    assign committed = head_scalar ? {{(FLAG_W-4){1'b0}}, head_flags[3:0]}
                                   : head_flags;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        ready_d  = (count_d < DEPTH_C);
        sticky_d = (clr_flags ? '0 : sticky_q) | (pop ? committed : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            sticky_q <= '0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr_q]   <= in_result;
            flags_mem[wptr_q]  <= in_flags;
            rd_mem[wptr_q]     <= in_rd;
            scalar_mem[wptr_q] <= in_scalar;
            wben_mem[wptr_q]   <= in_wb_en;
        end
    end

    assign in_ready     = ready_q;
    assign count        = count_q;
    assign sticky_flags = sticky_q;

    assign wr_en   = not_empty & head_wben;
    assign wr_addr = rd_mem[rptr_q];
    assign wr_data = data_mem[rptr_q];
    // Scalar ops only produce a meaningful lane 0.
    assign wr_mask = {{(LANES-1){~head_scalar}}, 1'b1};

endmodule
`default_nettype wire

// File: tb/tb_vec_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vec_wb_buffer
// Purpose : Self-checking bench for vec_wb_buffer against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vec_wb_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int DW     = LANES * LANE_W;
    localparam int FW     = LANES * 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_result;
    logic [FW-1:0]     in_flags;
    logic              in_scalar;
    logic [ADDR_W-1:0] in_rd;
    logic              in_wb_en;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DW-1:0]     wr_data;
    logic [LANES-1:0]  wr_mask;
    logic              clr_flags;
    logic [FW-1:0]     sticky_flags;
    logic [2:0]        count;

    vec_wb_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .in_scalar    (in_scalar),
        .in_rd        (in_rd),
        .in_wb_en     (in_wb_en),
        .wr_en        (wr_en),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_mask      (wr_mask),
        .clr_flags    (clr_flags),
        .sticky_flags (sticky_flags),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]     res;
        logic [FW-1:0]     flags;
        logic              scalar;
        logic [ADDR_W-1:0] rd;
        logic              wben;
    } entry_t;

    entry_t        mq[$];
    logic [FW-1:0] m_sticky;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [FW-1:0] rand_fw();
        return {$urandom(), $urandom()};
    endfunction

    // Compare at the falling edge, then advance the model to the next rising edge.
    task automatic step();
        logic [FW-1:0] commit;
        bit do_push, do_pop;
        @(negedge clk);
        chk("count", count, mq.size());
        chk("in_ready", in_ready, (mq.size() < DEPTH));
        chk("wr_en", wr_en, (mq.size() > 0) && mq[0].wben);
        chk("sticky", sticky_flags, m_sticky);
        if (mq.size() > 0) begin
            chk("wr_addr", wr_addr, mq[0].rd);
            chk("wr_data", wr_data, mq[0].res);
            chk("wr_mask", wr_mask, mq[0].scalar ? 16'h0001 : 16'hFFFF);
        end
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = (mq.size() > 0) && (!mq[0].wben || wr_ready);
        if (clr_flags) m_sticky = '0;
        if (do_pop) begin
            commit = mq[0].flags;
            if (mq[0].scalar) commit = {{(FW-4){1'b0}}, commit[3:0]};
            m_sticky = m_sticky | commit;
            void'(mq.pop_front());
        end
        if (do_push) mq.push_back('{in_result, in_flags, in_scalar, in_rd, in_wb_en});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [ADDR_W-1:0] rd, input logic [DW-1:0] res,
                         input logic [FW-1:0] fl, input bit sc, input bit wb);
        in_valid  = v;
        in_rd     = rd;
        in_result = res;
        in_flags  = fl;
        in_scalar = sc;
        in_wb_en  = wb;
    endtask

    initial begin
        logic [DW-1:0] vres;
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        wr_ready  = 1'b1;
        clr_flags = 1'b0;
        m_sticky  = '0;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset / idle
        chk("rst_count", count, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sticky", sticky_flags, 0);
        step();
        step();

        // Single vector push
        vres = '0;
        vres[15:0]    = 16'hFE20;
        vres[255:240] = 16'hFD60;
        drive(1'b1, 5'd5, vres, 64'h2, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("vec_wr_en", wr_en, 1);
        chk("vec_wr_addr", wr_addr, 5);
        chk("vec_wr_mask", wr_mask, 16'hFFFF);
        chk("vec_wr_data", wr_data, vres);
        step();
        chk("vec_count_after", count, 0);
        chk("vec_sticky", sticky_flags, 64'h2);

        // Scalar push (clear the earlier sticky bits at the same time)
        vres = rand_dw();
        vres[15:0] = 16'hFE20;
        drive(1'b1, 5'd7, vres, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("scl_wr_mask", wr_mask, 16'h0001);
        chk("scl_wr_lane0", wr_data[15:0], 16'hFE20);
        step();
        chk("scl_sticky", sticky_flags, 64'h1);

        // Backpressure
        wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ADDR_W'(i), rand_dw(), rand_fw(), 1'b0, 1'b1);
            step();
        end
        drive(1'b1, 5'd4, rand_dw(), rand_fw(), 1'b0, 1'b1);
        step();
        chk("bp_full_count", count, 4);
        chk("bp_full_ready", in_ready, 0);
        wr_ready = 1'b1;
        chk("bp_head0", wr_addr, 0);
        step();
        chk("bp_head1", wr_addr, 1);
        chk("bp_ready_after_pop", in_ready, 1);
        chk("bp_count_after_pop", count, 3);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && mq.size() > 0; i++) step();
        chk("bp_drained", count, 0);

        // Wrap and concurrency
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ADDR_W'(i + 8), rand_dw(), rand_fw(), ($urandom_range(0, 1) == 1), 1'b1);
            step();
            chk("wrap_count", count, 1);
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step();
        chk("wrap_empty", count, 0);

        // Flags-only entry under backpressure
        wr_ready  = 1'b0;
        clr_flags = 1'b1;
        drive(1'b1, 5'd3, rand_dw(), 64'h80, 1'b0, 1'b0);
        step();
        clr_flags = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("fo_wr_en", wr_en, 0);
        chk("fo_count", count, 1);
        step();
        chk("fo_retired", count, 0);
        chk("fo_sticky", sticky_flags, 64'h80);

        // Clear coincident with pop
        wr_ready = 1'b1;
        drive(1'b1, 5'd9, rand_dw(), 64'h4, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_pop_sticky", sticky_flags, 64'h4);

        // Reset with entries queued
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADDR_W'(20 + i), rand_dw(), rand_fw(), 1'b0, 1'b1);
            step();
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("pre_rst_count", count, 3);
        rst = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_wr_en", wr_en, 0);
        chk("async_rst_sticky", sticky_flags, 0);
        mq.delete();
        m_sticky = '0;
        #1 rst = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 60), ADDR_W'($urandom()), rand_dw(), rand_fw(),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
            wr_ready  = ($urandom_range(0, 99) < 55);
            clr_flags = ($urandom_range(0, 19) == 0);
            step();
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        wr_ready  = 1'b1;
        clr_flags = 1'b0;
        for (int i = 0; i < 20 && mq.size() > 0; i++) step();
        step();
        chk("final_empty", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
